l2_cmd_responder: RTL and testbench
===================================

Name: l2_cmd_responder

Overview:
- Next-level (L2-side) responder for the L1 data cache command interface.
- Accepts line-address commands (READ_OUT 2'b01, WRITE_OUT/RW_OUT 2'b10) from the L1 into a small FIFO.
- Services each command in order against a backing-memory req/ack handshake.
- Returns a one-cycle completion pulse and keeps read/write/overflow statistics.

Parameters:
- ADDR_W, 26: line-address width (byte address bits [31:6]).
- FIFO_DEPTH, 4: command FIFO entries; power of two, at least 2.
- CNT_W, 32: statistics counter width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  L1 command strobe; one command per asserted cycle.
- cmd_in  input  2  L1 command: 00 none, 01 read, 10 write, 11 reserved.
- add_in  input  ADDR_W  L1 line address.
- mem_req  output  1  backing-memory request, held until ack.
- mem_we  output  1  1 = write request, 0 = read request.
- mem_addr  output  32  byte address, {line, 6'b0}.
- mem_ack  input  1  memory completion; only sampled while mem_req=1.
- resp_valid  output  1  one-cycle completion pulse.
- resp_cmd  output  2  command just completed.
- resp_addr  output  ADDR_W  line address just completed.
- busy  output  1  FIFO non-empty or FSM not IDLE.
- overflow  output  1  sticky; set on the first dropped command.
- rd_count  output  CNT_W  completed reads.
- wr_count  output  CNT_W  completed writes.
- drop_count  output  CNT_W  dropped commands.

Behaviour:
- Reset (asynchronous, immediate on rst_n=0):
  - FIFO emptied, FSM to IDLE.
  - All outputs 0, including mem_req, resp_valid, overflow and all counters.
  - An in-flight request is abandoned; a mem_ack arriving after reset is ignored.
- Accept rule:
  - A push is requested when cmd_valid=1 and cmd_in is 01 or 10.
  - cmd_in 00 or 11 with cmd_valid=1 is ignored and not counted.
- FIFO full:
  - If full and no pop happens in the same cycle, the command is dropped.
  - A drop increments drop_count and sets overflow.
  - If full and a pop happens in the same cycle, the push succeeds.
- Pointer wrap: pointers wrap modulo FIFO_DEPTH; full/empty are decided with an extra wrap bit.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop the head into current-command registers and go to REQ.
  - REQ: mem_req=1, mem_we=(cmd==10), mem_addr={addr,6'b0}. Stay until mem_ack=1, then go to RESP.
  - RESP: resp_valid=1 with resp_cmd/resp_addr driven; increment rd_count or wr_count; go to IDLE.
- Throughput: one command completes at most every 3 cycles (IDLE, REQ, RESP).
- Latency into an empty, idle block with mem_ack tied high:
  - Push at edge t.
  - mem_req high after edge t+1.
  - resp_valid high after edge t+2 for exactly one cycle.
- Output timing:
  - mem_req, mem_we and mem_addr are registered.
  - They are stable for the whole REQ dwell and 0 outside REQ.
  - resp_cmd/resp_addr hold their last values outside RESP.
- Ordering: strictly FIFO; no merging or reordering, even for duplicate addresses.
- Counter width: counters wrap modulo 2^CNT_W; no saturation.
- overflow clears only on reset.
- busy is combinational from FIFO count and state.

Decomposition:
- Shared package l2_pkg holds:
  - command encodings CMD_NONE=2'b00, CMD_READ=2'b01, CMD_WRITE=2'b10;
  - the FSM state enum {IDLE, REQ, RESP};
  - the LINE_OFFSET_BITS=6 constant.
- The L1 data cache should take its READ_OUT/WRITE_OUT values from l2_pkg.
- One sub-module: l2_cmd_fifo, a parameterised synchronous FIFO with push, pop, full, empty and async active-low reset.
- The top level holds the FSM and the counters.

Test Plan:
1. Reset, then read 0x0ABCDEF with mem_ack tied 1:
   - mem_req=1, mem_we=0, mem_addr=0x2AF37BC0 after edge t+1;
   - resp_valid pulse with resp_cmd=01 after edge t+2;
   - rd_count=1.
2. Write 0x0000001 with mem_ack delayed 5 cycles:
   - mem_req held 5 cycles with mem_we=1, mem_addr=0x00000040;
   - resp_cmd=10, wr_count=1.
3. Back-to-back pushes with mem_ack=0: 6 consecutive reads, addresses 1..6:
   - first 4 accepted, 5th and 6th dropped;
   - drop_count=2, overflow=1;
   - after releasing mem_ack, responses appear in order for addresses 1..4 only.
4. FIFO full with a pop in the push cycle: push a new command in the cycle IDLE pops:
   - command accepted, drop_count unchanged.
5. cmd_valid=1 with cmd_in=11, then 00:
   - no push, busy stays 0, all counters 0.
6. Assert rst_n=0 while in REQ:
   - mem_req drops immediately with no clock;
   - after release, busy=0 and all counters are 0;
   - a stale mem_ack produces no resp_valid.

Source files
------------

// File: rtl/l2_pkg.sv
// Shared L1/L2 command interface definitions: command encodings, responder FSM states,
// and cache-line geometry.
package l2_pkg;

  localparam logic [1:0] CMD_NONE  = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;

  localparam int unsigned LINE_OFFSET_BITS = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } l2_state_e;

  // Only read and write are queued; none and the reserved code are ignored.
  function automatic logic is_queued_cmd(input logic [1:0] cmd);
    return (cmd == CMD_READ) || (cmd == CMD_WRITE);
  endfunction

endpackage

// File: rtl/l2_cmd_fifo.sv
// Synchronous command FIFO; wrap-bit pointers distinguish full from empty.
// A push into a full FIFO succeeds only when a pop happens in the same cycle.
module l2_cmd_fifo #(
  parameter int unsigned WIDTH = 28,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data_c,
  output logic             full_c,
  output logic             empty_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr_q;
  logic [PW-1:0]    rptr_q;
  logic             wr_en;
  logic             rd_en;

  assign empty_c   = (wptr_q == rptr_q);
  assign full_c    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign rd_data_c = mem[rptr_q[AW-1:0]];
  assign wr_en     = push && (!full_c || pop);
  assign rd_en     = pop && !empty_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (wr_en) wptr_q <= wptr_q + PW'(1);
      if (rd_en) rptr_q <= rptr_q + PW'(1);
    end
  end

  // Storage needs no reset; the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/l2_cmd_responder.sv
// L2-side responder: queues L1 line commands, services them in order against a
// backing-memory req/ack handshake, and reports completions and statistics.
module l2_cmd_responder
  import l2_pkg::*;
#(
  parameter int unsigned ADDR_W     = 26,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd_in,
  input  logic [ADDR_W-1:0] add_in,
  output logic              mem_req,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  input  logic              mem_ack,
  output logic              resp_valid,
  output logic [1:0]        resp_cmd,
  output logic [ADDR_W-1:0] resp_addr,
  output logic              busy,
  output logic              overflow,
  output logic [CNT_W-1:0]  rd_count,
  output logic [CNT_W-1:0]  wr_count,
  output logic [CNT_W-1:0]  drop_count
);

  localparam int unsigned ENTRY_W = ADDR_W + 2;

  l2_state_e         state_q, state_d;
  logic [1:0]        cur_cmd_q, cur_cmd_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic              mem_req_d, mem_we_d, resp_valid_d, overflow_d;
  logic [31:0]       mem_addr_d;
  logic [1:0]        resp_cmd_d;
  logic [ADDR_W-1:0] resp_addr_d;
  logic [CNT_W-1:0]  rd_count_d, wr_count_d, drop_count_d;

  logic               push_req, pop;
  logic               fifo_full, fifo_empty;
  logic [ENTRY_W-1:0] head;

  assign push_req = cmd_valid && is_queued_cmd(cmd_in);
  assign busy     = !fifo_empty || (state_q != IDLE);

  l2_cmd_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_req),
    .pop       (pop),
    .wr_data   ({cmd_in, add_in}),
    .rd_data_c (head),
    .full_c    (fifo_full),
    .empty_c   (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cur_cmd_q  <= CMD_NONE;
      cur_addr_q <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      resp_valid <= 1'b0;
      resp_cmd   <= CMD_NONE;
      resp_addr  <= '0;
      overflow   <= 1'b0;
      rd_count   <= '0;
      wr_count   <= '0;
      drop_count <= '0;
    end else begin
      state_q    <= state_d;
      cur_cmd_q  <= cur_cmd_d;
      cur_addr_q <= cur_addr_d;
      mem_req    <= mem_req_d;
      mem_we     <= mem_we_d;
      mem_addr   <= mem_addr_d;
      resp_valid <= resp_valid_d;
      resp_cmd   <= resp_cmd_d;
      resp_addr  <= resp_addr_d;
      overflow   <= overflow_d;
      rd_count   <= rd_count_d;
      wr_count   <= wr_count_d;
      drop_count <= drop_count_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cur_cmd_d    = cur_cmd_q;
    cur_addr_d   = cur_addr_q;
    pop          = 1'b0;
    resp_valid_d = 1'b0;
    resp_cmd_d   = resp_cmd;
    resp_addr_d  = resp_addr;
    rd_count_d   = rd_count;
    wr_count_d   = wr_count;
    drop_count_d = drop_count;
    overflow_d   = overflow;

    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          cur_cmd_d  = head[ENTRY_W-1 -: 2];
          cur_addr_d = head[ADDR_W-1:0];
          state_d    = REQ;
        end
      end
      REQ: begin
        if (mem_ack) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_cmd_d   = cur_cmd_q;
          resp_addr_d  = cur_addr_q;
          if (cur_cmd_q == CMD_WRITE) wr_count_d = wr_count + CNT_W'(1);
          else                        rd_count_d = rd_count + CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A same-cycle pop frees a slot, so only a push with no pop is dropped.
    if (push_req && fifo_full && !pop) begin
      drop_count_d = drop_count + CNT_W'(1);
      overflow_d   = 1'b1;
    end

    // Memory outputs are registered from the next state so they track REQ exactly.
    mem_req_d  = (state_d == REQ);
    mem_we_d   = (state_d == REQ) && (cur_cmd_d == CMD_WRITE);
    mem_addr_d = (state_d == REQ) ? 32'({cur_addr_d, {LINE_OFFSET_BITS{1'b0}}}) : 32'd0;
  end

endmodule

// File: tb/tb_l2_cmd_responder.sv
// Directed bench for l2_cmd_responder: a per-cycle vector table for reset, ignored
// commands and the basic read, then hand sequences for stalls, overflow and reset.
module tb_l2_cmd_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic [1:0]  cmd_in;
  logic [25:0] add_in;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr;
  logic        resp_valid;
  logic [1:0]  resp_cmd;
  logic [25:0] resp_addr;
  logic        busy, overflow;
  logic [31:0] rd_count, wr_count, drop_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  l2_cmd_responder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_in     (cmd_in),
    .add_in     (add_in),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .resp_valid (resp_valid),
    .resp_cmd   (resp_cmd),
    .resp_addr  (resp_addr),
    .busy       (busy),
    .overflow   (overflow),
    .rd_count   (rd_count),
    .wr_count   (wr_count),
    .drop_count (drop_count)
  );

  typedef struct {
    logic        cv;
    logic [1:0]  cmd;
    logic [25:0] addr;
    logic        ack;
    logic        e_req;
    logic        e_we;
    logic [31:0] e_maddr;
    logic        e_rv;
    logic [1:0]  e_rcmd;
    logic [25:0] e_raddr;
    logic        e_busy;
    logic [31:0] e_rd;
  } vec_t;

  vec_t vt [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic cv, input logic [1:0] cmd, input logic [25:0] addr);
    cmd_valid = cv;
    cmd_in    = cmd;
    add_in    = addr;
  endtask

  initial begin
    logic [25:0] exp_order [5];
    int idx;

    // Ignored commands first, then a read into an idle block with mem_ack tied high.
    vt[0] = '{1'b1, 2'b11, 26'h123,     1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 2'b00, 26'h0,       1'b0, 32'd0};
    vt[1] = '{1'b1, 2'b00, 26'h456,     1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 2'b00, 26'h0,       1'b0, 32'd0};
    vt[2] = '{1'b1, 2'b01, 26'h0ABCDEF, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 2'b00, 26'h0,       1'b1, 32'd0};
    vt[3] = '{1'b0, 2'b00, 26'h0,       1'b1, 1'b1, 1'b0, 32'h2AF37BC0, 1'b0, 2'b00, 26'h0,       1'b1, 32'd0};
    vt[4] = '{1'b0, 2'b00, 26'h0,       1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 2'b01, 26'h0ABCDEF, 1'b1, 32'd1};
    vt[5] = '{1'b0, 2'b00, 26'h0,       1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 2'b01, 26'h0ABCDEF, 1'b0, 32'd1};

    rst_n = 1'b0;
    drive(1'b0, 2'b00, 26'h0);
    mem_ack = 1'b0;
    step();
    step();
    chk("rst_mem_req", 64'(mem_req), 64'(0));
    chk("rst_resp_valid", 64'(resp_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_overflow", 64'(overflow), 64'(0));
    chk("rst_counts", 64'(rd_count | wr_count | drop_count), 64'(0));
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 6; i++) begin
      drive(vt[i].cv, vt[i].cmd, vt[i].addr);
      mem_ack = vt[i].ack;
      step();
      chk($sformatf("v%0d_mem_req", i), 64'(mem_req), 64'(vt[i].e_req));
      chk($sformatf("v%0d_mem_we", i), 64'(mem_we), 64'(vt[i].e_we));
      chk($sformatf("v%0d_mem_addr", i), 64'(mem_addr), 64'(vt[i].e_maddr));
      chk($sformatf("v%0d_resp_valid", i), 64'(resp_valid), 64'(vt[i].e_rv));
      chk($sformatf("v%0d_resp_cmd", i), 64'(resp_cmd), 64'(vt[i].e_rcmd));
      chk($sformatf("v%0d_resp_addr", i), 64'(resp_addr), 64'(vt[i].e_raddr));
      chk($sformatf("v%0d_busy", i), 64'(busy), 64'(vt[i].e_busy));
      chk($sformatf("v%0d_rd_count", i), 64'(rd_count), 64'(vt[i].e_rd));
      chk($sformatf("v%0d_wr_drop", i), 64'(wr_count | drop_count), 64'(0));
    end

    // Write with mem_ack withheld: request must stay up and stable for 5 cycles.
    mem_ack = 1'b0;
    drive(1'b1, 2'b10, 26'h1);
    step();
    drive(1'b0, 2'b00, 26'h0);
    chk("wr_push_req", 64'(mem_req), 64'(0));
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("wr_hold%0d_req", i), 64'(mem_req), 64'(1));
      chk($sformatf("wr_hold%0d_we", i), 64'(mem_we), 64'(1));
      chk($sformatf("wr_hold%0d_addr", i), 64'(mem_addr), 64'(32'h40));
    end
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("wr_resp_valid", 64'(resp_valid), 64'(1));
    chk("wr_resp_cmd", 64'(resp_cmd), 64'(2'b10));
    chk("wr_resp_addr", 64'(resp_addr), 64'(26'h1));
    chk("wr_mem_req_low", 64'(mem_req), 64'(0));
    chk("wr_count", 64'(wr_count), 64'(1));
    step();
    chk("wr_idle_busy", 64'(busy), 64'(0));
    chk("wr_overflow", 64'(overflow), 64'(0));

    // Park the FSM in REQ, then six back-to-back reads: four fit, two drop.
    drive(1'b1, 2'b10, 26'h3F);
    step();
    drive(1'b0, 2'b00, 26'h0);
    step();
    chk("ovf_park_req", 64'(mem_req), 64'(1));
    chk("ovf_park_addr", 64'(mem_addr), 64'(32'hFC0));
    for (int i = 1; i <= 6; i++) begin
      drive(1'b1, 2'b01, 26'(i));
      step();
    end
    drive(1'b0, 2'b00, 26'h0);
    chk("ovf_drop_count", 64'(drop_count), 64'(2));
    chk("ovf_flag", 64'(overflow), 64'(1));
    chk("ovf_rd_count", 64'(rd_count), 64'(1));

    // Finish the parked write, then push into the full FIFO on the IDLE pop cycle.
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("park_resp_valid", 64'(resp_valid), 64'(1));
    chk("park_resp_addr", 64'(resp_addr), 64'(26'h3F));
    chk("park_wr_count", 64'(wr_count), 64'(2));
    step();
    chk("pop_cycle_busy", 64'(busy), 64'(1));
    drive(1'b1, 2'b01, 26'h7);
    step();
    drive(1'b0, 2'b00, 26'h0);
    chk("pushpop_drop_count", 64'(drop_count), 64'(2));
    chk("pushpop_mem_addr", 64'(mem_addr), 64'(32'h40));

    exp_order[0] = 26'h1;
    exp_order[1] = 26'h2;
    exp_order[2] = 26'h3;
    exp_order[3] = 26'h4;
    exp_order[4] = 26'h7;
    idx = 0;
    mem_ack = 1'b1;
    for (int c = 0; c < 40 && idx < 5; c++) begin
      step();
      if (resp_valid) begin
        chk($sformatf("order%0d_addr", idx), 64'(resp_addr), 64'(exp_order[idx]));
        chk($sformatf("order%0d_cmd", idx), 64'(resp_cmd), 64'(2'b01));
        idx++;
      end
    end
    chk("order_resp_total", 64'(idx), 64'(5));
    for (int c = 0; c < 4; c++) begin
      step();
      chk($sformatf("order_tail%0d_rv", c), 64'(resp_valid), 64'(0));
    end
    chk("order_rd_count", 64'(rd_count), 64'(6));
    chk("order_busy", 64'(busy), 64'(0));
    mem_ack = 1'b0;

    // Asynchronous reset while in REQ, followed by a stale mem_ack.
    drive(1'b1, 2'b01, 26'h9);
    step();
    drive(1'b0, 2'b00, 26'h0);
    step();
    chk("rreq_mem_req", 64'(mem_req), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_mem_req", 64'(mem_req), 64'(0));
    chk("async_busy", 64'(busy), 64'(0));
    chk("async_overflow", 64'(overflow), 64'(0));
    mem_ack = 1'b1;
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      chk($sformatf("stale%0d_resp_valid", c), 64'(resp_valid), 64'(0));
      chk($sformatf("stale%0d_mem_req", c), 64'(mem_req), 64'(0));
    end
    chk("post_rst_busy", 64'(busy), 64'(0));
    chk("post_rst_counts", 64'(rd_count | wr_count | drop_count), 64'(0));
    mem_ack = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
